wam_lvl: RTL and testbench

Parametrised synchronous successor to the Whac-A-Mole hardness controller. It holds the current difficulty level. The level moves on manual left/right button edges and on score-carry promotion, and it drops automatically after consecutive misses. Auto-change cooldown, a lock input and status flags are included. Per-level mole age and spawn ratio are produced from a registered lookup. The block sits between the button/score logic and the mole generator.

---
 rtl/wam_lvl.sv | 141 ++++++++++++++
 tb/tb_wam_lvl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wam_lvl.sv
// Whac-A-Mole difficulty level controller: manual and auto level moves, miss-driven
// demotion, auto-event cooldown, lock, and registered per-level age/spawn-ratio lookup.
module wam_lvl #(
   parameter int N_LVL    = 11,
   parameter int LW       = 4,
   parameter int MISS_LIM = 3,
   parameter int COOL     = 8,
   parameter bit AUTO_DN  = 1'b1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          lft,
   input  logic          rgt,
   input  logic          cout0,
   input  logic          miss,
   input  logic          lock,
   output logic [LW-1:0] hrdn,
   output logic [3:0]    age,
   output logic [7:0]    rto,
   output logic          at_min,
   output logic          at_max,
   output logic          chg
);

   typedef enum logic {IDLE, HOLD} cool_e;

   localparam logic [LW-1:0] MAX_LVL = LW'(N_LVL - 1);
   localparam logic [3:0]    LIM     = 4'(MISS_LIM);
   localparam logic [7:0]    COOL_V  = 8'(COOL);

   // Levels 10 and above share the hardest setting.
   localparam logic [3:0] AGE_T [16] = '{4'd14, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4, 4'd4,
                                         4'd3,  4'd3,  4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
   localparam logic [7:0] RTO_T [16] = '{8'd42,  8'd62,  8'd76,  8'd87,  8'd93,  8'd96,
                                         8'd93,  8'd87,  8'd76,  8'd61,  8'd200, 8'd200,
                                         8'd200, 8'd200, 8'd200, 8'd200};

   logic          lft_q, rgt_q, cout_q;
   logic [LW-1:0] hrdn_q, hrdn_d;
   logic [3:0]    age_q, age_d;
   logic [7:0]    rto_q, rto_d;
   logic          at_min_q, at_min_d, at_max_q, at_max_d, chg_q, chg_d;
   logic [3:0]    miss_q, miss_d;
   logic [7:0]    cnt_q, cnt_d;
   cool_e         st_q, st_d;

   logic lft_e, rgt_e, cout_e, miss_hit, cool_ok;
   logic auto_up, auto_dn, up, dn, inc, dec, auto_app;

   always_comb begin
      lft_e    = lft & ~lft_q;
      rgt_e    = rgt & ~rgt_q;
      cout_e   = cout0 & ~cout_q;
      miss_hit = miss && (miss_q >= LIM - 4'd1);
      cool_ok  = (st_q == IDLE);
      auto_up  = cout_e & cool_ok;
      auto_dn  = AUTO_DN & miss_hit & cool_ok;
      up       = rgt_e | auto_up;
      dn       = lft_e | auto_dn;
      inc      = ~lock & up & ~dn & (hrdn_q != MAX_LVL);
      dec      = ~lock & dn & ~up & (hrdn_q != '0);
      auto_app = (inc & auto_up) | (dec & auto_dn);

      hrdn_d = hrdn_q;
      if (inc) hrdn_d = hrdn_q + LW'(1);
      else if (dec) hrdn_d = hrdn_q - LW'(1);
      chg_d    = inc | dec;
      at_min_d = (hrdn_d == '0);
      at_max_d = (hrdn_d == MAX_LVL);
      age_d    = AGE_T[4'(hrdn_d)];
      rto_d    = RTO_T[4'(hrdn_d)];

      miss_d = miss_q;
      if (lock || cout_e || lft_e || rgt_e || miss_hit) miss_d = '0;
      else if (miss && (miss_q < LIM)) miss_d = miss_q + 4'd1;

      // Cooldown only reacts to auto changes that actually moved the level.
      st_d  = st_q;
      cnt_d = cnt_q;
      if (!lock) begin
         case (st_q)
            IDLE: begin
               if (auto_app && (COOL_V != '0)) begin
                  st_d  = HOLD;
                  cnt_d = COOL_V;
               end
            end
            HOLD: begin
               if (cnt_q <= 8'd1) begin
                  st_d  = IDLE;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: begin
               st_d  = IDLE;
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         lft_q    <= 1'b0;
         rgt_q    <= 1'b0;
         cout_q   <= 1'b0;
         hrdn_q   <= '0;
         age_q    <= 4'd14;
         rto_q    <= 8'd42;
         at_min_q <= 1'b1;
         at_max_q <= 1'b0;
         chg_q    <= 1'b0;
         miss_q   <= '0;
         cnt_q    <= '0;
         st_q     <= IDLE;
      end else begin
         lft_q    <= lft;
         rgt_q    <= rgt;
         cout_q   <= cout0;
         hrdn_q   <= hrdn_d;
         age_q    <= age_d;
         rto_q    <= rto_d;
         at_min_q <= at_min_d;
         at_max_q <= at_max_d;
         chg_q    <= chg_d;
         miss_q   <= miss_d;
         cnt_q    <= cnt_d;
         st_q     <= st_d;
      end
   end

   assign hrdn   = hrdn_q;
   assign age    = age_q;
   assign rto    = rto_q;
   assign at_min = at_min_q;
   assign at_max = at_max_q;
   assign chg    = chg_q;

endmodule

// File: tb/tb_wam_lvl.sv
// Directed scoreboard bench for wam_lvl: expected level/chg pushed per step, checked after each edge.
module tb_wam_lvl;

   logic clk = 1'b0, clr = 1'b0;
   logic lft = 1'b0, rgt = 1'b0, cout0 = 1'b0, miss = 1'b0, lock = 1'b0;
   logic [3:0] hrdn, age;
   logic [7:0] rto;
   logic at_min, at_max, chg;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int    h;
      bit    c;
      string tag;
   } exp_t;
   exp_t sb[$];

   int age_t [0:10] = '{14, 11, 9, 7, 6, 5, 4, 4, 3, 3, 1};
   int rto_t [0:10] = '{42, 62, 76, 87, 93, 96, 93, 87, 76, 61, 200};

   wam_lvl #(.N_LVL(11), .LW(4), .MISS_LIM(3), .COOL(8), .AUTO_DN(1'b1)) dut (
      .clk(clk), .clr(clr), .lft(lft), .rgt(rgt), .cout0(cout0), .miss(miss), .lock(lock),
      .hrdn(hrdn), .age(age), .rto(rto), .at_min(at_min), .at_max(at_max), .chg(chg)
   );

   always #5 clk = ~clk;

   task automatic push(input int h, input bit c, input string tag);
      exp_t e;
      e.h = h;
      e.c = c;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic chk();
      exp_t e;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0d expected>0", sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_assert++;
         assert (hrdn === 4'(e.h)) else begin
            n_fail++; $error("FAIL %s hrdn observed=%0d expected=%0d", e.tag, hrdn, e.h);
         end
         n_assert++;
         assert (age === 4'(age_t[e.h])) else begin
            n_fail++; $error("FAIL %s age observed=%0d expected=%0d", e.tag, age, age_t[e.h]);
         end
         n_assert++;
         assert (rto === 8'(rto_t[e.h])) else begin
            n_fail++; $error("FAIL %s rto observed=%0d expected=%0d", e.tag, rto, rto_t[e.h]);
         end
         n_assert++;
         assert (at_min === (e.h == 0)) else begin
            n_fail++; $error("FAIL %s at_min observed=%b expected=%b", e.tag, at_min, (e.h == 0));
         end
         n_assert++;
         assert (at_max === (e.h == 10)) else begin
            n_fail++; $error("FAIL %s at_max observed=%b expected=%b", e.tag, at_max, (e.h == 10));
         end
         n_assert++;
         assert (chg === e.c) else begin
            n_fail++; $error("FAIL %s chg observed=%b expected=%b", e.tag, chg, e.c);
         end
      end
   endtask

   // Drive one cycle of inputs, then check the state after the following edge.
   task automatic st(input bit l, input bit r, input bit c, input bit m, input bit k,
                     input int h, input bit cg, input string tag);
      lft = l; rgt = r; cout0 = c; miss = m; lock = k;
      push(h, cg, tag);
      @(posedge clk);
      #1;
      chk();
   endtask

   task automatic idle(input int n, input int h, input string tag);
      for (int i = 0; i < n; i++) st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, 1'b0, tag);
   endtask

   // Asserted between edges so the check sees the asynchronous effect.
   task automatic do_reset(input string tag);
      lft = 1'b0; rgt = 1'b0; cout0 = 1'b0; miss = 1'b0; lock = 1'b0;
      clr = 1'b1;
      #2;
      push(0, 1'b0, tag);
      chk();
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #1;
      do_reset("t1_rst");
      // 1: manual harder, one request per held press
      st(0, 1, 0, 0, 0, 1, 1, "t1_r1"); idle(1, 1, "t1_i1");
      st(0, 1, 0, 0, 0, 2, 1, "t1_r2"); idle(1, 2, "t1_i2");
      st(0, 1, 0, 0, 0, 3, 1, "t1_r3"); idle(1, 3, "t1_i3");
      st(0, 1, 0, 0, 0, 4, 1, "t1_held_a");
      st(0, 1, 0, 0, 0, 4, 0, "t1_held_b");
      idle(1, 4, "t1_i4");

      // 2: saturation at both ends
      do_reset("t2_rst");
      st(1, 0, 0, 0, 0, 0, 0, "t2_lft_sat"); idle(1, 0, "t2_i0");
      for (int i = 0; i < 12; i++) begin
         st(0, 1, 0, 0, 0, (i + 1 > 10) ? 10 : i + 1, (i < 10), "t2_up");
         idle(1, (i + 1 > 10) ? 10 : i + 1, "t2_up_i");
      end

      // 3: auto harder with cooldown; manual acts during HOLD
      do_reset("t3_rst");
      st(0, 1, 0, 0, 0, 1, 1, "t3_r1"); idle(1, 1, "t3_i1");
      st(0, 1, 0, 0, 0, 2, 1, "t3_r2"); idle(1, 2, "t3_i2");
      st(0, 0, 1, 0, 0, 3, 1, "t3_c1"); idle(3, 3, "t3_hold");
      st(0, 0, 1, 0, 0, 3, 0, "t3_c2_cool"); idle(5, 3, "t3_hold2");
      st(0, 0, 1, 0, 0, 4, 1, "t3_c3"); idle(1, 4, "t3_i3");
      st(0, 1, 0, 0, 0, 5, 1, "t3_r_hold"); idle(1, 5, "t3_i4");

      // 4: miss-driven demotion; cout0 clears the miss count
      idle(10, 5, "t4_wait");
      st(0, 0, 0, 1, 0, 5, 0, "t4_m1"); idle(1, 5, "t4_i");
      st(0, 0, 0, 1, 0, 5, 0, "t4_m2"); idle(1, 5, "t4_i");
      st(0, 0, 0, 1, 0, 4, 1, "t4_m3_dn"); idle(1, 4, "t4_i");
      idle(10, 4, "t4_wait2");
      st(0, 0, 0, 1, 0, 4, 0, "t4_m1b"); idle(1, 4, "t4_i");
      st(0, 0, 0, 1, 0, 4, 0, "t4_m2b"); idle(1, 4, "t4_i");
      st(0, 0, 1, 0, 0, 5, 1, "t4_c"); idle(10, 5, "t4_wait3");
      st(0, 0, 0, 1, 0, 5, 0, "t4_cleared1"); idle(1, 5, "t4_i");
      st(0, 0, 0, 1, 0, 5, 0, "t4_cleared2"); idle(1, 5, "t4_i");
      st(0, 0, 0, 1, 0, 4, 1, "t4_dn2"); idle(1, 4, "t4_i");

      // 5: conflicting edges, lock discards edges and clears misses
      st(1, 1, 0, 0, 0, 4, 0, "t5_both"); idle(1, 4, "t5_i");
      st(0, 0, 0, 0, 1, 4, 0, "t5_lock");
      st(0, 1, 0, 0, 1, 4, 0, "t5_lock_r1");
      st(0, 0, 0, 0, 1, 4, 0, "t5_lock_i");
      st(0, 1, 0, 0, 1, 4, 0, "t5_lock_r2");
      st(0, 0, 0, 0, 0, 4, 0, "t5_unlock"); idle(1, 4, "t5_i");
      st(0, 1, 0, 0, 1, 4, 0, "t5_lock_r3");
      st(0, 1, 0, 0, 0, 4, 0, "t5_held_release"); idle(1, 4, "t5_i");
      idle(10, 4, "t5_wait");
      st(0, 0, 0, 1, 0, 4, 0, "t5_m1"); idle(1, 4, "t5_i");
      st(0, 0, 0, 1, 0, 4, 0, "t5_m2"); idle(1, 4, "t5_i");
      st(0, 0, 0, 0, 1, 4, 0, "t5_lock_clr");
      st(0, 0, 0, 1, 0, 4, 0, "t5_m_after"); idle(1, 4, "t5_i");
      st(0, 0, 0, 1, 0, 4, 0, "t5_m_after2"); idle(1, 4, "t5_i");
      st(0, 0, 0, 1, 0, 3, 1, "t5_dn"); idle(1, 3, "t5_i");

      // 6: async reset mid-HOLD clears cooldown
      st(0, 1, 0, 0, 0, 4, 1, "t6_r1"); idle(1, 4, "t6_i");
      st(0, 1, 0, 0, 0, 5, 1, "t6_r2"); idle(1, 5, "t6_i");
      st(0, 1, 0, 0, 0, 6, 1, "t6_r3"); idle(1, 6, "t6_i");
      idle(10, 6, "t6_wait");
      st(0, 0, 1, 0, 0, 7, 1, "t6_c"); idle(2, 7, "t6_hold");
      do_reset("t6_async");
      st(0, 0, 1, 0, 0, 1, 1, "t6_c_after"); idle(1, 1, "t6_i");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
